// File: rtl/sm83_pkg.sv
// rtl/sm83_pkg.sv - shared types and constants for the sm83 OAM DMA block
package sm83_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_DELAY,
        DMA_READ,
        DMA_WRITE
    } dma_state_t;

    localparam addr_t DMA_REG_ADDR    = 16'hFF46;
    localparam addr_t OAM_BASE        = 16'hFE00;
    localparam int    DMA_XFER_LEN    = 160;
    localparam int    DMA_START_DELAY = 1;

    // Pages E0..FF mirror C0..DF (echo RAM), so they fold back by 0x20.
    function automatic data_t dma_src_hi(input data_t reg_val);
        return (reg_val <= 8'hDF) ? reg_val : data_t'(reg_val - 8'h20);
    endfunction

endpackage

// File: rtl/sm83_oam_dma.sv
// rtl/sm83_oam_dma.sv - OAM DMA engine and core/bus master mux
module sm83_oam_dma #(
    parameter sm83_pkg::addr_t DMA_REG_ADDR = sm83_pkg::DMA_REG_ADDR,
    parameter sm83_pkg::addr_t OAM_BASE     = sm83_pkg::OAM_BASE,
    parameter int              XFER_LEN     = sm83_pkg::DMA_XFER_LEN,
    parameter int              START_DELAY  = sm83_pkg::DMA_START_DELAY
) (
    input  logic            clk,
    input  logic            rst,
    input  sm83_pkg::addr_t core_addr,
    input  sm83_pkg::data_t core_w_data,
    input  logic            core_w_wen,
    output sm83_pkg::data_t core_r_data,
    output sm83_pkg::addr_t bus_addr,
    output sm83_pkg::data_t bus_w_data,
    output logic            bus_w_wen,
    input  sm83_pkg::data_t bus_r_data,
    output logic            dma_active
);
    import sm83_pkg::*;

    localparam dma_state_t START_STATE = (START_DELAY == 0) ? DMA_READ : DMA_DELAY;
    localparam data_t      LAST_IDX    = data_t'(XFER_LEN - 1);
    localparam logic [15:0] DLY_LOAD   = (START_DELAY == 0) ? 16'd0 : 16'(START_DELAY - 1);

    dma_state_t  r_state;
    data_t       r_idx;
    data_t       r_dma_reg;
    data_t       r_byte_q;
    data_t       r_src_hi;
    logic [15:0] r_dly;
    logic        r_active;

    logic        w_reg_hit;
    logic        w_reg_wr;

    assign w_reg_hit  = (core_addr == DMA_REG_ADDR);
    assign w_reg_wr   = w_reg_hit & core_w_wen;
    assign dma_active = r_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DMA_IDLE;
            r_idx     <= '0;
            r_dma_reg <= 8'hFF;
            r_byte_q  <= '0;
            r_src_hi  <= '0;
            r_dly     <= '0;
            r_active  <= 1'b0;
        end else begin
            if (r_state == DMA_READ) begin
                r_byte_q <= bus_r_data;
            end
            // A register write (re)starts the copy from any state; the bus
            // action of the current cycle has already been presented.
            if (w_reg_wr) begin
                r_dma_reg <= core_w_data;
                r_src_hi  <= dma_src_hi(core_w_data);
                r_idx     <= '0;
                r_dly     <= DLY_LOAD;
                r_state   <= START_STATE;
                r_active  <= 1'b1;
            end else begin
                case (r_state)
                    DMA_DELAY: begin
                        if (r_dly == 16'd0) begin
                            r_state <= DMA_READ;
                        end else begin
                            r_dly <= r_dly - 16'd1;
                        end
                    end
                    DMA_READ: begin
                        r_state <= DMA_WRITE;
                    end
                    DMA_WRITE: begin
                        if (r_idx == LAST_IDX) begin
                            r_idx    <= '0;
                            r_state  <= DMA_IDLE;
                            r_active <= 1'b0;
                        end else begin
                            r_idx   <= r_idx + 8'd1;
                            r_state <= DMA_READ;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_comb begin
        bus_addr   = core_addr;
        bus_w_data = core_w_data;
        bus_w_wen  = core_w_wen & ~w_reg_hit;
        case (r_state)
            DMA_DELAY: begin
                bus_addr   = OAM_BASE;
                bus_w_data = r_byte_q;
                bus_w_wen  = 1'b0;
            end
            DMA_READ: begin
                bus_addr   = {r_src_hi, 8'h00} + {8'h00, r_idx};
                bus_w_data = r_byte_q;
                bus_w_wen  = 1'b0;
            end
            DMA_WRITE: begin
                bus_addr   = OAM_BASE + {8'h00, r_idx};
                bus_w_data = r_byte_q;
                bus_w_wen  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        core_r_data = bus_r_data;
        if (w_reg_hit) begin
            core_r_data = r_dma_reg;
        end else if (r_active) begin
            core_r_data = 8'hFF;
        end
    end

endmodule

// File: tb/tb_sm83_oam_dma.sv
// tb/tb_sm83_oam_dma.sv - self-checking bench for sm83_oam_dma
module tb_sm83_oam_dma;

    localparam int          D    = 1;
    localparam int          L    = 160;
    localparam logic [15:0] REG  = 16'hFF46;
    localparam logic [15:0] OAM  = 16'hFE00;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] core_addr;
    logic [7:0]  core_w_data;
    logic        core_w_wen;
    logic [7:0]  core_r_data;
    logic [15:0] bus_addr;
    logic [7:0]  bus_w_data;
    logic        bus_w_wen;
    logic [7:0]  bus_r_data;
    logic        dma_active;

    logic [7:0]  mem [0:65535];

    int checks = 0;
    int errors = 0;
    int oam_wr = 0;
    int c050_wr = 0;
    int hi_wr = 0;
    int act_cnt = 0;

    always #5 clk = ~clk;

    assign bus_r_data = mem[bus_addr];

    sm83_oam_dma #(
        .DMA_REG_ADDR(REG),
        .OAM_BASE    (OAM),
        .XFER_LEN    (L),
        .START_DELAY (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_addr  (core_addr),
        .core_w_data(core_w_data),
        .core_w_wen (core_w_wen),
        .core_r_data(core_r_data),
        .bus_addr   (bus_addr),
        .bus_w_data (bus_w_data),
        .bus_w_wen  (bus_w_wen),
        .bus_r_data (bus_r_data),
        .dma_active (dma_active)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory environment: combinational read, write on the clock edge.
    always @(posedge clk) begin
        if (bus_w_wen === 1'b1) begin
            mem[bus_addr] <= bus_w_data;
            if (bus_addr >= OAM && bus_addr < OAM + 16'(L)) oam_wr <= oam_wr + 1;
            if (bus_addr >= 16'hFE32 && bus_addr < OAM + 16'(L)) hi_wr <= hi_wr + 1;
            if (bus_addr == 16'hC050) c050_wr <= c050_wr + 1;
        end
    end

    always @(negedge clk) begin
        if (dma_active === 1'b1) act_cnt <= act_cnt + 1;
    end

    // Transfer model: a start opens a busy window of D + 2*L cycles; offset o
    // inside it is delay (o<D), then alternating read/write of byte (o-D)/2.
    logic       m_busy = 1'b0;
    int         m_off = 0;
    logic [7:0] m_reg = 8'hFF;
    logic [7:0] m_src = 8'h00;
    logic       check_en = 1'b0;

    function automatic logic [7:0] map_src(input logic [7:0] r);
        return (r <= 8'hDF) ? r : r - 8'h20;
    endfunction

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            m_busy   <= 1'b0;
            m_reg    <= 8'hFF;
            m_off    <= 0;
            check_en <= 1'b1;
        end else if (core_w_wen === 1'b1 && core_addr == REG) begin
            m_reg  <= core_w_data;
            m_src  <= map_src(core_w_data);
            m_busy <= 1'b1;
            m_off  <= 0;
        end else if (m_busy) begin
            if (m_off + 1 == D + 2 * L) m_busy <= 1'b0;
            m_off <= m_off + 1;
        end
    end

    logic [15:0] e_addr;
    logic        e_wen;
    logic [7:0]  e_data;
    logic [7:0]  e_rd;
    int          e_k;

    always @(negedge clk) begin
        if (check_en) begin
            e_data = 8'h00;
            e_k    = 0;
            if (m_busy) begin
                if (m_off < D) begin
                    e_addr = OAM;
                    e_wen  = 1'b0;
                end else begin
                    e_k = (m_off - D) / 2;
                    if (((m_off - D) % 2) == 0) begin
                        e_addr = {m_src, 8'h00} + 16'(e_k);
                        e_wen  = 1'b0;
                    end else begin
                        e_addr = OAM + 16'(e_k);
                        e_wen  = 1'b1;
                        e_data = mem[{m_src, 8'h00} + 16'(e_k)];
                    end
                end
            end else begin
                e_addr = core_addr;
                e_wen  = core_w_wen && (core_addr != REG);
                e_data = core_w_data;
            end
            if (core_addr == REG) e_rd = m_reg;
            else if (m_busy)      e_rd = 8'hFF;
            else                  e_rd = mem[core_addr];
            chk("cyc_dma_active", 32'(dma_active), 32'(m_busy));
            chk("cyc_bus_addr", 32'(bus_addr), 32'(e_addr));
            chk("cyc_bus_w_wen", 32'(bus_w_wen), 32'(e_wen));
            if (e_wen) chk("cyc_bus_w_data", 32'(bus_w_data), 32'(e_data));
            chk("cyc_core_r_data", 32'(core_r_data), 32'(e_rd));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic core_write(input logic [15:0] a, input logic [7:0] d);
        core_addr   = a;
        core_w_data = d;
        core_w_wen  = 1'b1;
        @(posedge clk);
        #1;
        core_w_wen  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (dma_active !== 1'b0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_idle_timeout", 32'(dma_active), 32'd0);
    endtask

    int a0, w0, c0, h0;

    initial begin
        rst         = 1'b1;
        core_addr   = 16'h0000;
        core_w_data = 8'h00;
        core_w_wen  = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            mem[i] <= (i >= 16'hC000 && i < 16'hE000) ? (8'(i) ^ 8'hA5) : 8'h00;
        end
        step(2);
        rst = 1'b0;

        // Reset state
        chk("reset_active", 32'(dma_active), 32'd0);
        core_addr = REG;
        #1;
        chk("reset_reg_read", 32'(core_r_data), 32'hFF);

        // Idle passthrough
        core_addr   = 16'hC010;
        core_w_data = 8'h5A;
        core_w_wen  = 1'b1;
        #1;
        chk("idle_wr_wen", 32'(bus_w_wen), 32'd1);
        chk("idle_wr_addr", 32'(bus_addr), 32'hC010);
        @(posedge clk);
        #1;
        core_w_wen = 1'b0;
        #1;
        chk("idle_rd_data", 32'(core_r_data), 32'h5A);
        chk("idle_active", 32'(dma_active), 32'd0);
        mem[16'hC010] <= 8'h10 ^ 8'hA5;
        step(2);

        // Basic transfer
        for (int i = 0; i < L; i++) mem[OAM + 16'(i)] <= 8'h00;
        step(1);
        a0 = act_cnt;
        w0 = oam_wr;
        c0 = c050_wr;
        core_write(REG, 8'hC0);
        step(40);
        core_addr = 16'hC000;
        #1;
        chk("iso_rd_ff", 32'(core_r_data), 32'hFF);
        core_addr = REG;
        #1;
        chk("iso_reg_rd", 32'(core_r_data), 32'hC0);
        core_write(16'hC050, 8'h77);
        core_addr = 16'h0000;
        wait_idle();
        step(1);
        chk("basic_busy_cycles", 32'(act_cnt - a0), 32'd321);
        chk("basic_oam_writes", 32'(oam_wr - w0), 32'd160);
        chk("iso_c050_dropped", 32'(c050_wr - c0), 32'd0);
        chk("basic_fe00", 32'(mem[16'hFE00]), 32'hA5);
        chk("basic_fe9f", 32'(mem[16'hFE9F]), 32'h3A);
        for (int k = 0; k < L; k++) begin
            chk("basic_oam_byte", 32'(mem[OAM + 16'(k)]), 32'(8'(k) ^ 8'hA5));
        end

        // Echo mirror
        core_write(REG, 8'hE0);
        step(1);
        chk("echo_first_read", 32'(bus_addr), 32'hC000);
        wait_idle();
        step(1);

        // Restart during byte 10 write
        w0 = oam_wr;
        core_write(REG, 8'hC0);
        step(22);
        core_addr   = REG;
        core_w_data = 8'hC1;
        core_w_wen  = 1'b1;
        #1;
        chk("restart_wr_wen", 32'(bus_w_wen), 32'd1);
        chk("restart_wr_addr", 32'(bus_addr), 32'hFE0A);
        @(posedge clk);
        #1;
        core_w_wen = 1'b0;
        #1;
        chk("restart_delay_active", 32'(dma_active), 32'd1);
        chk("restart_delay_wen", 32'(bus_w_wen), 32'd0);
        step(1);
        chk("restart_read_addr", 32'(bus_addr), 32'hC100);
        wait_idle();
        step(1);
        chk("restart_total_writes", 32'(oam_wr - w0), 32'd171);

        // Reset mid-transfer at byte 50
        h0 = hi_wr;
        core_write(REG, 8'hC0);
        step(101);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_active", 32'(dma_active), 32'd0);
        core_addr = 16'h1234;
        #1;
        chk("rst_passthrough", 32'(bus_addr), 32'h1234);
        core_addr = REG;
        #1;
        chk("rst_reg_read", 32'(core_r_data), 32'hFF);
        step(400);
        chk("rst_no_hi_writes", 32'(hi_wr - h0), 32'd0);
        chk("rst_still_idle", 32'(dma_active), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
